// File: rtl/ram_arbiter_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state and arbiter FSM state.
package ram_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bundle of the shared-RAM arbiter; slave = arbiter, master = environment.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]  req_ren;
    logic [NREQ-1:0]  req_wen;
    logic [NREQ-1:0]  req_lock;
    word_t [NREQ-1:0] req_addr;
    word_t [NREQ-1:0] req_store;
    logic [NREQ-1:0]  req_wait;
    word_t [NREQ-1:0] req_load;
    logic [NREQ-1:0]  req_err;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, req_err, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of active at or after ptr, wrapping.
// Zero latency; no flow control, vld simply reports whether any bit is set.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] active,
    input  logic [PW-1:0]   ptr,
    output logic            vld,
    output logic [PW-1:0]   idx
);

    int c;

    always_comb begin
        vld = 1'b0;
        idx = '0;
        c   = 0;
        for (int d = 0; d < NREQ; d++) begin
            // explicit wrap keeps non-power-of-2 NREQ correct
            c = int'(ptr) + d;
            if (c >= NREQ) c = c - NREQ;
            if (!vld && active[c[PW-1:0]]) begin
                vld = 1'b1;
                idx = c[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters; grant-to-RAM-enable takes 1 cycle.
// Requesters stall on req_wait until ACCESS releases it for one cycle; locked holders keep the grant.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input logic          CLK,
    input logic          nRST,
    ram_arbiter_if.slave bus
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
    localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

    arb_state_t      state;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   rr_ptr;
    logic [TW-1:0]   tcount;

    logic [NREQ-1:0] active;
    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   grant_nxt;
    logic            g_active;
    logic            g_access;
    logic            g_fail;

    assign active = bus.req_ren | bus.req_wen;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .active (active),
        .ptr    (rr_ptr),
        .vld    (pick_vld),
        .idx    (pick_idx)
    );

    // A granted requester that goes inactive is treated as an abort, not a transfer.
    assign g_active  = (state == ISSUE) && active[grant];
    assign g_access  = g_active && (bus.ramstate == ACCESS);
    assign g_fail    = g_active && ((bus.ramstate == ERROR) ||
                                    (bus.ramstate != ACCESS && tcount == TLAST));
    assign grant_nxt = (grant == LAST_IDX) ? '0 : grant + 1'b1;

    always_comb begin
        bus.ramWEN   = g_active && bus.req_wen[grant];
        bus.ramREN   = g_active && bus.req_ren[grant] && !bus.req_wen[grant];
        bus.ramaddr  = g_active ? bus.req_addr[grant]  : '0;
        bus.ramstore = g_active ? bus.req_store[grant] : '0;
        bus.req_wait = '1;
        bus.req_load = '0;
        bus.req_err  = '0;
        if (state == ISSUE) bus.req_load[grant] = bus.ramload;
        if (g_access)       bus.req_wait[grant] = 1'b0;
        if (g_fail)         bus.req_err[grant]  = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            tcount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant  <= pick_idx;
                        tcount <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!g_active) begin
                        state <= IDLE;
                    end else if (g_access) begin
                        if (bus.req_lock[grant]) begin
                            tcount <= '0;
                        end else begin
                            state  <= IDLE;
                            rr_ptr <= grant_nxt;
                        end
                    end else if (g_fail) begin
                        state  <= IDLE;
                        rr_ptr <= grant_nxt;
                    end else if (tcount != TMAX) begin
                        tcount <= tcount + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a transaction-level model checked every cycle.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TO = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    ram_arbiter_if #(.NREQ(N)) bus ();

    ram_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc++;

    typedef struct {
        int    idx;
        int    cyc;
        word_t load;
        word_t addr;
        word_t store;
        logic  ren;
        logic  wen;
    } ev_t;

    ev_t done_q[$];
    ev_t err_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ev_t get_done(input int k);
        ev_t e;
        e = '{idx: -1, cyc: -1, load: '0, addr: '0, store: '0, ren: 1'b0, wen: 1'b0};
        if (k < done_q.size()) e = done_q[k];
        return e;
    endfunction

    function automatic ev_t get_err(input int k);
        ev_t e;
        e = '{idx: -1, cyc: -1, load: '0, addr: '0, store: '0, ren: 1'b0, wen: 1'b0};
        if (k < err_q.size()) e = err_q[k];
        return e;
    endfunction

    // RAM responder: BUSY for `lat` cycles then ACCESS; mode 1 stays BUSY, mode 2 answers ERROR.
    int    lat      = 0;
    int    mode     = 0;
    word_t ram_data = 32'hDEADBEEF;
    initial begin
        int bcnt;
        bcnt         = 0;
        bus.ramstate = FREE;
        bus.ramload  = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (bus.ramREN || bus.ramWEN) begin
                if (mode == 2) begin
                    bus.ramstate = ERROR;
                end else if (mode == 0 && bcnt >= lat) begin
                    bus.ramstate = ACCESS;
                    bcnt = 0;
                end else begin
                    bus.ramstate = BUSY;
                    bcnt++;
                end
            end else begin
                bus.ramstate = FREE;
                bcnt = 0;
            end
            bus.ramload = (bus.ramstate == ACCESS) ? ram_data : 32'h5A5A0000;
        end
    end

    // Model: owner (-1 = none), priority pointer, stalled cycles of the current grant.
    initial begin
        int m_own, m_ptr, m_stall, n_own, n_ptr, n_stall, o;
        logic [N-1:0] e_wait, e_err;
        word_t [N-1:0] e_load;
        logic e_ren, e_wen;
        word_t e_addr, e_store;
        m_own = -1; m_ptr = 0; m_stall = 0;
        forever begin
            @(negedge CLK);
            #3;
            e_wait = '1; e_err = '0; e_load = '0;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
            if (!nRST) begin
                m_own = -1; m_ptr = 0; m_stall = 0;
                n_own = -1; n_ptr = 0; n_stall = 0;
            end else if (m_own < 0) begin
                n_own = -1; n_ptr = m_ptr; n_stall = 0;
                for (int d = N - 1; d >= 0; d--)
                    if (bus.req_ren[(m_ptr + d) % N] || bus.req_wen[(m_ptr + d) % N])
                        n_own = (m_ptr + d) % N;
            end else begin
                o = m_own;
                n_own = o; n_ptr = m_ptr; n_stall = m_stall;
                e_load[o] = bus.ramload;
                if (!(bus.req_ren[o] || bus.req_wen[o])) begin
                    n_own = -1;
                end else begin
                    e_wen   = bus.req_wen[o];
                    e_ren   = !bus.req_wen[o];
                    e_addr  = bus.req_addr[o];
                    e_store = bus.req_store[o];
                    if (bus.ramstate == ACCESS) begin
                        e_wait[o] = 1'b0;
                        if (bus.req_lock[o]) n_stall = 0;
                        else begin n_own = -1; n_ptr = (o + 1) % N; end
                    end else if (bus.ramstate == ERROR || m_stall == TO - 1) begin
                        e_err[o] = 1'b1;
                        n_own = -1; n_ptr = (o + 1) % N;
                    end else begin
                        n_stall = m_stall + 1;
                    end
                end
            end
            chk("req_wait", bus.req_wait, e_wait);
            chk("req_err", bus.req_err, e_err);
            chk("req_load", bus.req_load, e_load);
            chk("ramREN", bus.ramREN, e_ren);
            chk("ramWEN", bus.ramWEN, e_wen);
            chk("ramaddr", bus.ramaddr, e_addr);
            chk("ramstore", bus.ramstore, e_store);
            for (int i = 0; i < N; i++) begin
                if (bus.req_wait[i] === 1'b0)
                    done_q.push_back('{idx: i, cyc: cyc, load: bus.req_load[i], addr: bus.ramaddr,
                                       store: bus.ramstore, ren: bus.ramREN, wen: bus.ramWEN});
                if (bus.req_err[i] === 1'b1)
                    err_q.push_back('{idx: i, cyc: cyc, load: bus.req_load[i], addr: bus.ramaddr,
                                      store: bus.ramstore, ren: bus.ramREN, wen: bus.ramWEN});
            end
            @(posedge CLK);
            if (!nRST) begin m_own = -1; m_ptr = 0; m_stall = 0; end
            else begin m_own = n_own; m_ptr = n_ptr; m_stall = n_stall; end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic clear_reqs();
        bus.req_ren = '0; bus.req_wen = '0; bus.req_lock = '0;
        bus.req_addr = '0; bus.req_store = '0;
    endtask

    task automatic wait_done(input int target, input int budget, input string what);
        int k = 0;
        while (done_q.size() < target && k < budget) begin tick(1); k++; end
        checks++;
        if (done_q.size() < target) begin
            errors++;
            $display("FAIL %s: timed out with %0d completions, need %0d", what, done_q.size(), target);
        end
    endtask

    task automatic wait_err(input int target, input int budget, input string what);
        int k = 0;
        while (err_q.size() < target && k < budget) begin tick(1); k++; end
        checks++;
        if (err_q.size() < target) begin
            errors++;
            $display("FAIL %s: timed out with %0d error pulses, need %0d", what, err_q.size(), target);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        ev_t e0, e1, e2, e3, e4;
        nRST = 1'b0;
        clear_reqs();
        tick(2);
        chk("reset_wait", bus.req_wait, 4'hF);
        chk("reset_ren", bus.ramREN, 1'b0);
        chk("reset_load", bus.req_load, 128'h0);
        chk("reset_ptr", dut.rr_ptr, 2'd0);
        nRST = 1'b1;
        tick(1);

        // single read from requester 2, two BUSY cycles then ACCESS
        done_q.delete();
        lat = 2; ram_data = 32'hDEADBEEF;
        c0 = cyc;
        bus.req_addr[2] = 32'h40; bus.req_ren[2] = 1'b1;
        #1;
        chk("s1_idle_ren", bus.ramREN, 1'b0);
        tick(1);
        chk("s1_ren_next_cycle", bus.ramREN, 1'b1);
        wait_done(1, 20, "s1_done");
        clear_reqs();
        e0 = get_done(0);
        chk("s1_idx", e0.idx, 2);
        chk("s1_cycle", e0.cyc - c0, 3);
        chk("s1_load", e0.load, 32'hDEADBEEF);
        chk("s1_addr", e0.addr, 32'h40);
        chk("s1_ptr", dut.rr_ptr, 2'd3);

        // read+write on requester 1: write wins
        done_q.delete();
        lat = 0;
        bus.req_addr[1] = 32'h10; bus.req_store[1] = 32'h1234;
        bus.req_ren[1] = 1'b1; bus.req_wen[1] = 1'b1;
        wait_done(1, 20, "s2_done");
        clear_reqs();
        e0 = get_done(0);
        chk("s2_idx", e0.idx, 1);
        chk("s2_wen", e0.wen, 1'b1);
        chk("s2_ren", e0.ren, 1'b0);
        chk("s2_store", e0.store, 32'h1234);
        chk("s2_ptr", dut.rr_ptr, 2'd2);

        // abort: requester 2 drops before ACCESS, keeps priority
        done_q.delete();
        lat = 5;
        bus.req_addr[2] = 32'h50; bus.req_ren[2] = 1'b1;
        tick(2);
        chk("s3_ren_on", bus.ramREN, 1'b1);
        bus.req_ren[2] = 1'b0;
        #1;
        chk("s3_ren_off", bus.ramREN, 1'b0);
        tick(1);
        chk("s3_state", dut.state, IDLE);
        chk("s3_ptr", dut.rr_ptr, 2'd2);
        chk("s3_no_done", done_q.size(), 0);

        // asynchronous reset in the middle of ISSUE
        bus.req_addr[3] = 32'h60; bus.req_ren[3] = 1'b1;
        tick(2);
        chk("s4_ren_on", bus.ramREN, 1'b1);
        nRST = 1'b0;
        #1;
        chk("s4_ren_off", bus.ramREN, 1'b0);
        chk("s4_wait", bus.req_wait, 4'hF);
        chk("s4_ptr", dut.rr_ptr, 2'd0);
        clear_reqs();
        tick(2);
        nRST = 1'b1;
        tick(1);

        // fairness: all four requesters active, ACCESS on first ISSUE cycle
        done_q.delete();
        lat = 0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i] = 32'h100 + 32'(i * 4);
            bus.req_ren[i]  = 1'b1;
        end
        wait_done(5, 60, "s5_done");
        clear_reqs();
        e0 = get_done(0); e1 = get_done(1); e2 = get_done(2); e3 = get_done(3); e4 = get_done(4);
        chk("s5_order", {e0.idx[3:0], e1.idx[3:0], e2.idx[3:0], e3.idx[3:0], e4.idx[3:0]}, 20'h01230);
        chk("s5_gap", e1.cyc - e0.cyc, 2);
        chk("s5_period", e4.cyc - e0.cyc, 8);

        // lock: two words to requester 0 with no IDLE gap, requester 1 waits
        done_q.delete();
        lat = 1;
        bus.req_addr[0] = 32'h80; bus.req_ren[0] = 1'b1; bus.req_lock[0] = 1'b1;
        tick(1);
        bus.req_addr[1] = 32'h200; bus.req_ren[1] = 1'b1;
        wait_done(1, 20, "s6_word0");
        bus.req_addr[0] = 32'h84;
        wait_done(2, 20, "s6_word1");
        bus.req_ren[0] = 1'b0; bus.req_lock[0] = 1'b0;
        wait_done(3, 20, "s6_req1");
        clear_reqs();
        e0 = get_done(0); e1 = get_done(1); e2 = get_done(2);
        chk("s6_w0", {e0.idx[3:0], e0.addr}, {4'd0, 32'h80});
        chk("s6_w1", {e1.idx[3:0], e1.addr}, {4'd0, 32'h84});
        chk("s6_no_gap", e1.cyc - e0.cyc, 2);
        chk("s6_req1", {e2.idx[3:0], e2.addr}, {4'd1, 32'h200});
        chk("s6_req1_cycle", e2.cyc - e1.cyc, 4);

        // timeout: RAM stuck BUSY, error on 4th ISSUE cycle
        done_q.delete(); err_q.delete();
        mode = 1;
        c0 = cyc;
        bus.req_addr[3] = 32'h70; bus.req_ren[3] = 1'b1;
        wait_err(1, 20, "s7_err");
        clear_reqs();
        mode = 0;
        e0 = get_err(0);
        chk("s7_idx", e0.idx, 3);
        chk("s7_cycle", e0.cyc - c0, 4);
        chk("s7_no_done", done_q.size(), 0);
        chk("s7_ptr", dut.rr_ptr, 2'd0);

        // RAM ERROR: immediate error pulse
        err_q.delete();
        mode = 2;
        c0 = cyc;
        bus.req_addr[0] = 32'h90; bus.req_ren[0] = 1'b1;
        wait_err(1, 20, "s8_err");
        clear_reqs();
        mode = 0;
        e0 = get_err(0);
        chk("s8_idx", e0.idx, 0);
        chk("s8_cycle", e0.cyc - c0, 1);
        chk("s8_ptr", dut.rr_ptr, 2'd1);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin arbiter that shares the single-ported RAM among NREQ requesters (per-core instruction and data ports behind memory_control).
- Grants one requester at a time and forwards its enables, address and store data to RAM.
- Returns ramload and a one-cycle wait release on ACCESS.
- Supports locked back-to-back transfers (block fill/writeback), abort, ERROR propagation and a stall timeout.

Parameters:
NREQ, 4, number of requesters (>=2)
TIMEOUT, 64, max cycles in ISSUE without ACCESS before error (>=1)

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
req_ren  in  NREQ  per-requester read enable
req_wen  in  NREQ  per-requester write enable
req_lock  in  NREQ  keep grant after current ACCESS
req_addr  in  NREQ x 32 (word_t)  address
req_store  in  NREQ x 32 (word_t)  write data
req_wait  out  NREQ  1 = stall; 0 for exactly one cycle on completion
req_load  out  NREQ x 32  read data, valid when req_wait bit is 0
req_err  out  NREQ  one-cycle pulse on ERROR or timeout
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR

Behaviour:
- Reset: nRST asynchronous, active-low; clock CLK.
  - state=IDLE, grant=0, rr_ptr=0, tcount=0.
  - All req_wait=1, req_load=0, req_err=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - Reset mid-transfer drops RAM enables immediately (combinational off state).
- Requester active = req_ren|req_wen. If both are set, write wins: ramWEN=1, ramREN=0.
- States: IDLE, ISSUE.
- IDLE:
  - RAM enables 0, all req_wait=1.
  - If any requester is active, grant = first active index searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Register grant, tcount=0, go to ISSUE. Request-to-RAM-enable latency is 1 cycle.
- ISSUE, RAM side:
  - Drive RAM from live req_* of grant: enables, ramaddr, ramstore.
  - req_load[grant]=ramload combinationally. Other req_load=0.
- ISSUE, ramstate==ACCESS:
  - req_wait[grant]=0 this cycle only.
  - If req_lock[grant]: stay ISSUE, tcount=0.
  - Else: go to IDLE, rr_ptr=(grant+1) mod NREQ.
- ISSUE, ramstate==ERROR:
  - req_err[grant]=1, req_wait stays 1.
  - Go to IDLE, rr_ptr=grant+1.
- ISSUE, FREE or BUSY:
  - tcount increments, saturating at TIMEOUT.
  - When tcount==TIMEOUT-1 and no ACCESS: pulse req_err[grant], go to IDLE, rr_ptr=grant+1.
- Abort: granted requester inactive in ISSUE (before ACCESS, or while locked after ACCESS):
  - RAM enables 0 that cycle, no wait release.
  - Go to IDLE, rr_ptr unchanged, so the aborted requester keeps priority.
- Minimum spacing between two unlocked grants is 1 IDLE cycle, so back-to-back single transfers from one requester take ACCESS latency + 1.
- Non-granted requesters always see req_wait=1.
- Worst-case wait with all NREQ requesters unlocked: (NREQ-1) transfers.
- Locked holders are unbounded except by timeout.
- tcount width $clog2(TIMEOUT+1). rr_ptr width $clog2(NREQ), wraps NREQ-1 -> 0 (non-power-of-2 NREQ handled by explicit compare).

Decomposition:
- cpu_types_pkg (existing) supplies word_t and ramstate_t. Add arb_state_t {IDLE, ISSUE} there.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: active mask, rr_ptr.
  - Outputs: valid, index.
  - Reusable for memory_control's core arbitration.

Test Plan:
- Single read: req_ren[2]=1 addr 0x40, RAM gives ACCESS after 2 BUSY cycles with ramload 0xDEADBEEF -> ramREN high from cycle 1; req_wait[2]=0 with req_load[2]=0xDEADBEEF for one cycle; rr_ptr=3.
- Fairness: all 4 requesters held active, unlocked, ACCESS each 1 cycle -> grant order 0,1,2,3,0; each completes once per 8 cycles.
- Read+write same requester: req_ren[1]=req_wen[1]=1, store 0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234.
- Lock: req_lock[0]=1 for two words (0x80, 0x84) while req_ren[1]=1 -> both words served to 0 with no IDLE gap; requester 1 granted only after req_lock[0] drops.
- Timeout/error: TIMEOUT=4, ramstate stuck BUSY -> req_err[3] pulses on 4th ISSUE cycle, then IDLE. Separately, ramstate=ERROR -> immediate req_err pulse.
- Abort and reset: requester 2 drops ren before ACCESS -> IDLE, rr_ptr unchanged. nRST low mid-ISSUE -> ramREN=0 and all req_wait=1 asynchronously.
